// File: rtl/fish_pkg.sv
// Shared widths, raster defaults, FSM state type and accumulator clear values
// for the fish_locator object finder.
package fish_pkg;

    localparam int XW    = 11;
    localparam int YW    = 10;
    localparam int RUNW  = 4;   // holds MIN_RUN up to 15
    localparam int PRESW = 3;   // holds MIN_FRAMES up to 7

    localparam logic [XW-1:0] H_ACTIVE_DEF = 11'd800;
    localparam logic [YW-1:0] V_ACTIVE_DEF = 10'd600;

    localparam logic [XW-1:0] MINX_CLR = 11'h7FF;
    localparam logic [YW-1:0] MINY_CLR = 10'h3FF;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } fish_state_e;

endpackage

// File: rtl/fish_locator_run_filter.sv
// Horizontal run-length filter: flags the pixel where a mask run first reaches
// MIN_RUN and reports the column where that run started.
module run_filter
    import fish_pkg::*;
#(
    parameter logic [XW-1:0] H_ACTIVE = H_ACTIVE_DEF,
    parameter logic [YW-1:0] V_ACTIVE = V_ACTIVE_DEF,
    parameter int            MIN_RUN  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          de,
    input  logic [XW-1:0] countx,
    input  logic [YW-1:0] county,
    input  logic          mask,
    input  logic          frame_start,
    output logic          hit,
    output logic [XW-1:0] cand_x
);

    localparam logic [RUNW-1:0] RUN_MAX  = RUNW'(MIN_RUN);
    localparam logic [XW-1:0]   RUN_BACK = XW'(MIN_RUN - 1);

    logic [RUNW-1:0] run_q;
    logic [RUNW-1:0] run_d;
    logic            pix_ok;

    always_comb begin
        pix_ok = de && (countx < H_ACTIVE) && (county < V_ACTIVE) && !frame_start;
        run_d  = '0;
        // Column 0 always restarts the count so a run cannot wrap across lines.
        if (pix_ok && mask && (countx != '0)) begin
            if (run_q == RUN_MAX) begin
                run_d = RUN_MAX;
            end else begin
                run_d = run_q + RUNW'(1);
            end
        end
        hit    = (run_d == RUN_MAX) && (run_q != RUN_MAX);
        cand_x = countx - RUN_BACK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/fish_locator.sv
// Per-frame bounding-box corner finder with a persistence filter on obj_valid.
// Results are committed on frame_start and held steady for the following frame.
module fish_locator
    import fish_pkg::*;
#(
    parameter logic [XW-1:0] H_ACTIVE   = H_ACTIVE_DEF,
    parameter logic [YW-1:0] V_ACTIVE   = V_ACTIVE_DEF,
    parameter int            MIN_RUN    = 4,
    parameter int            MIN_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          de,
    input  logic [XW-1:0] countx,
    input  logic [YW-1:0] county,
    input  logic          mask,
    input  logic          frame_start,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          obj_valid,
    output logic          frame_done
);

    localparam logic [PRESW-1:0] PRES_MAX = PRESW'(MIN_FRAMES);

    fish_state_e      state_q,      state_d;
    logic             acc_hit_q,    acc_hit_d;
    logic [XW-1:0]    acc_minx_q,   acc_minx_d;
    logic [YW-1:0]    acc_miny_q,   acc_miny_d;
    logic [XW-1:0]    x_q,          x_d;
    logic [YW-1:0]    y_q,          y_d;
    logic [PRESW-1:0] pres_q,       pres_d;
    logic             obj_valid_q,  obj_valid_d;
    logic             frame_done_q, frame_done_d;

    logic             hit;
    logic [XW-1:0]    cand_x;

    run_filter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .MIN_RUN  (MIN_RUN)
    ) u_run_filter (
        .clk         (clk),
        .rst         (rst),
        .de          (de),
        .countx      (countx),
        .county      (county),
        .mask        (mask),
        .frame_start (frame_start),
        .hit         (hit),
        .cand_x      (cand_x)
    );

    always_comb begin
        state_d      = state_q;
        acc_hit_d    = acc_hit_q;
        acc_minx_d   = acc_minx_q;
        acc_miny_d   = acc_miny_q;
        x_d          = x_q;
        y_d          = y_q;
        pres_d       = pres_q;
        obj_valid_d  = obj_valid_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                // The frame in progress at reset is incomplete, so it is dropped.
                if (frame_start) begin
                    state_d    = SCAN;
                    acc_hit_d  = 1'b0;
                    acc_minx_d = MINX_CLR;
                    acc_miny_d = MINY_CLR;
                end
            end
            SCAN: begin
                if (frame_start) begin
                    frame_done_d = 1'b1;
                    if (acc_hit_q) begin
                        x_d = acc_minx_q;
                        y_d = acc_miny_q;
                        if (pres_q == PRES_MAX) begin
                            pres_d = PRES_MAX;
                        end else begin
                            pres_d = pres_q + PRESW'(1);
                        end
                    end else begin
                        pres_d = '0;
                    end
                    obj_valid_d = (pres_d >= PRES_MAX);
                    acc_hit_d   = 1'b0;
                    acc_minx_d  = MINX_CLR;
                    acc_miny_d  = MINY_CLR;
                end else if (hit) begin
                    acc_hit_d = 1'b1;
                    if (cand_x < acc_minx_q) begin
                        acc_minx_d = cand_x;
                    end
                    if (county < acc_miny_q) begin
                        acc_miny_d = county;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_hit_q    <= 1'b0;
            acc_minx_q   <= MINX_CLR;
            acc_miny_q   <= MINY_CLR;
            x_q          <= '0;
            y_q          <= '0;
            pres_q       <= '0;
            obj_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_hit_q    <= acc_hit_d;
            acc_minx_q   <= acc_minx_d;
            acc_miny_q   <= acc_miny_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pres_q       <= pres_d;
            obj_valid_q  <= obj_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign obj_valid  = obj_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fish_locator.sv
// Directed bench for fish_locator: sparse pixel streams with hand-computed
// commit results (MIN_RUN=4, MIN_FRAMES=2).
module tb_fish_locator;

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic [10:0] countx;
    logic [9:0]  county;
    logic        mask;
    logic        frame_start;
    logic [10:0] x;
    logic [9:0]  y;
    logic        obj_valid;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fish_locator #(
        .H_ACTIVE   (11'd800),
        .V_ACTIVE   (10'd600),
        .MIN_RUN    (4),
        .MIN_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .de          (de),
        .countx      (countx),
        .county      (county),
        .mask        (mask),
        .frame_start (frame_start),
        .x           (x),
        .y           (y),
        .obj_valid   (obj_valid),
        .frame_done  (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One pixel cycle; returns 1 time unit after the rising edge.
    task automatic pix(input logic d, input logic [10:0] cx, input logic [9:0] cy,
                       input logic m, input logic fs);
        de          = d;
        countx      = cx;
        county      = cy;
        mask        = m;
        frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) pix(1'b0, 11'd0, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic run(input logic [10:0] x0, input logic [9:0] row, input int len);
        for (int i = 0; i < len; i++) pix(1'b1, x0 + 11'(i), row, 1'b1, 1'b0);
        pix(1'b1, x0 + 11'(len), row, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic rect();
        for (int r = 50; r <= 60; r++) run(11'd100, 10'(r), 10);
    endtask

    task automatic check_out(input string tag, input logic [10:0] ex, input logic [9:0] ey,
                             input logic ev, input logic ed);
        check({tag, " frame_done"}, 32'(frame_done), 32'(ed));
        check({tag, " x"},          32'(x),          32'(ex));
        check({tag, " y"},          32'(y),          32'(ey));
        check({tag, " obj_valid"},  32'(obj_valid),  32'(ev));
    endtask

    task automatic commit(input string tag, input logic [10:0] ex, input logic [9:0] ey,
                          input logic ev, input logic ed);
        pix(1'b0, 11'd0, 10'd0, 1'b0, 1'b1);
        check_out(tag, ex, ey, ev, ed);
        idle(1);
        check({tag, " done_low"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; de = 1'b0; mask = 1'b0; frame_start = 1'b0;
        countx = '0; county = '0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 11'd0, 10'd0, 1'b0, 1'b0);
        rst = 1'b0;
        idle(2);

        // First partial frame after reset is discarded.
        rect();
        commit("idle_discard", 11'd0, 10'd0, 1'b0, 1'b0);

        // Reset in the middle of a scanned frame, then a full frame is discarded again.
        run(11'd100, 10'd50, 10);
        run(11'd100, 10'd51, 10);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        rect();
        commit("rst_discard", 11'd0, 10'd0, 1'b0, 1'b0);

        rect();
        commit("frame1", 11'd100, 10'd50, 1'b0, 1'b1);
        rect();
        commit("frame2", 11'd100, 10'd50, 1'b1, 1'b1);

        // Short runs are noise; only the 4-pixel run qualifies.
        run(11'd200, 10'd20, 3);
        run(11'd5,   10'd30, 3);
        run(11'd300, 10'd80, 4);
        commit("noise", 11'd300, 10'd80, 1'b1, 1'b1);

        // A run split across two lines never qualifies.
        pix(1'b1, 11'd798, 10'd10, 1'b1, 1'b0);
        pix(1'b1, 11'd799, 10'd10, 1'b1, 1'b0);
        pix(1'b1, 11'd0,   10'd11, 1'b1, 1'b0);
        pix(1'b1, 11'd1,   10'd11, 1'b1, 1'b0);
        pix(1'b1, 11'd2,   10'd11, 1'b0, 1'b0);
        idle(1);
        commit("line_edge", 11'd300, 10'd80, 1'b0, 1'b1);

        // Out-of-window runs and a masked pixel under frame_start are ignored.
        run(11'd800,  10'd5,   6);
        run(11'd1000, 10'd5,   6);
        run(11'd10,   10'd600, 6);
        run(11'd10,   10'd700, 6);
        pix(1'b1, 11'd401, 10'd70, 1'b1, 1'b0);
        pix(1'b1, 11'd402, 10'd70, 1'b1, 1'b0);
        pix(1'b1, 11'd403, 10'd70, 1'b1, 1'b1);
        check_out("fs_de", 11'd300, 10'd80, 1'b0, 1'b1);
        pix(1'b1, 11'd404, 10'd70, 1'b1, 1'b0);
        pix(1'b1, 11'd405, 10'd70, 1'b0, 1'b0);
        idle(1);

        // Run ending on the last active pixel, directly before frame_start.
        for (int i = 796; i <= 799; i++) pix(1'b1, 11'(i), 10'd599, 1'b1, 1'b0);
        commit("corner1", 11'd796, 10'd599, 1'b0, 1'b1);
        for (int i = 796; i <= 799; i++) pix(1'b1, 11'(i), 10'd599, 1'b1, 1'b0);
        commit("corner2", 11'd796, 10'd599, 1'b1, 1'b1);

        // Empty frame after a valid object: hold position, drop valid.
        idle(5);
        check("hold x", 32'(x), 32'd796);
        commit("empty", 11'd796, 10'd599, 1'b0, 1'b1);

        // Back-to-back frame_start pulses each commit.
        pix(1'b0, 11'd0, 10'd0, 1'b0, 1'b1);
        check_out("b2b_a", 11'd796, 10'd599, 1'b0, 1'b1);
        pix(1'b0, 11'd0, 10'd0, 1'b0, 1'b1);
        check_out("b2b_b", 11'd796, 10'd599, 1'b0, 1'b1);
        idle(1);
        check("b2b done_low", 32'(frame_done), 32'd0);

        // Reset clears outputs without waiting for a clock edge.
        #3 rst = 1'b1;
        #1;
        check("async_rst x", 32'(x), 32'd0);
        check("async_rst y", 32'(y), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fish_locator.md
# fish_locator

Per-frame object locator that sits directly upstream of the point/marker overlay stage. It scans the binary foreground mask in raster order alongside the shared raster counters and rejects noise with a minimum horizontal run length. At each frame boundary it commits the top-left corner of the detected object's bounding box as `x`/`y`, and the overlay stage draws its marker relative to that position. A persistence filter gates `obj_valid`, so single-frame flicker never shows a marker.

## Interface
Parameters:
- `H_ACTIVE`, 11'd800: active pixels per line; pixels with `countx >= H_ACTIVE` are ignored.
- `V_ACTIVE`, 10'd600: active lines per frame; pixels with `county >= V_ACTIVE` are ignored.
- `MIN_RUN`, 4: consecutive mask pixels in one line needed for a qualifying hit; legal range 1..15.
- `MIN_FRAMES`, 2: consecutive frames with a hit needed before `obj_valid` asserts; legal range 1..7.

Ports:
- `clk` input 1: single system/pixel clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `de` input 1: pixel-valid / data enable.
- `countx` input 11: current raster column.
- `county` input 10: current raster row.
- `mask` input 1: foreground bit for the current pixel.
- `frame_start` input 1: one-cycle pulse during vertical blanking that marks the frame boundary.
- `x` output 11: committed bounding-box left edge.
- `y` output 10: committed bounding-box top edge.
- `obj_valid` output 1: object present for at least `MIN_FRAMES` consecutive frames.
- `frame_done` output 1: one-cycle pulse on every commit.

## Operation
- Pixel qualification: a pixel counts only when `de`=1, `countx < H_ACTIVE`, `county < V_ACTIVE` and `frame_start`=0.
- Run counter:
  - Clears when a pixel is not qualified, when `mask`=0, or when `countx`=0 (a run never spans two lines).
  - Otherwise increments, saturating at `MIN_RUN`.
- Hit: the cycle in which the run counter reaches `MIN_RUN`. Candidate column = `countx - (MIN_RUN-1)`, which never underflows.
- Accumulators, updated on every hit:
  - `acc_hit` is set.
  - `acc_minx` = min(`acc_minx`, candidate).
  - `acc_miny` = min(`acc_miny`, `county`).
  - Clear values: `acc_hit`=0, `acc_minx`=11'h7FF, `acc_miny`=10'h3FF.
- FSM states:
  - IDLE (reset state): all pixels are ignored. On `frame_start`, move to SCAN and clear the accumulators. No commit happens, so the first partial frame is discarded.
  - SCAN: accumulate hits. On `frame_start`, commit, clear the accumulators and stay in SCAN.
- Commit:
  - Pulse `frame_done`.
  - If `acc_hit`=1: load `x`←`acc_minx`, `y`←`acc_miny`, and increment `pres_cnt`, saturating at `MIN_FRAMES`.
  - If `acc_hit`=0: `x`/`y` hold their previous values and `pres_cnt`←0.
  - `obj_valid` ← (new `pres_cnt` ≥ `MIN_FRAMES`).
- Reset values: `x`=0, `y`=0, `obj_valid`=0, `frame_done`=0, `pres_cnt`=0, run counter 0, accumulators cleared, FSM in IDLE.
- Reset asserted mid-frame: all state is lost and the next full frame is discarded again, because the block restarts in IDLE.
- `frame_start` coinciding with `de`=1: that pixel is ignored and the run counter clears.

## Timing
- Hit-to-accumulator latency is 1 cycle: the accumulator reflects a hit on the edge after that pixel.
- Commit is registered on the `frame_start` edge, so `x`, `y`, `obj_valid` and `frame_done` change exactly 1 cycle after `frame_start` is sampled high.
- `frame_done` is high for exactly 1 cycle.
- Outputs are stable for the whole following frame, which is what the overlay stage needs for glitch-free drawing.
- The last active pixel of a frame is always included, provided it arrives at least one cycle before `frame_start`.
- Back-to-back `frame_start` pulses produce one commit each; the second one commits an empty frame.

## Structure
- Shared package `fish_pkg` holds:
  - width constants `XW`=11 and `YW`=10;
  - default `H_ACTIVE`/`V_ACTIVE`;
  - the FSM state typedef (IDLE, SCAN);
  - accumulator clear constants `MINX_CLR` and `MINY_CLR`.
- One sub-module, `run_filter`, contains the run counter and hit/candidate-column generation (`de`, `countx`, `county`, `mask` in; `hit`, `cand_x` out). Accumulators, FSM and persistence logic stay in `fish_locator`.

## Test plan
- Reset mid-frame, then drive one full frame containing a 10-pixel mask run at x=100, y=50, then `frame_start` → no commit, `x`=0, `y`=0, `obj_valid`=0.
- Settings `MIN_RUN`=4, `MIN_FRAMES`=2. Two full frames, each with mask=1 for x=100..109 on rows 50..60, each followed by `frame_start` → after the first: `x`=100, `y`=50, `obj_valid`=0; after the second: `obj_valid`=1. `frame_done` pulses 1 cycle after each `frame_start`.
- Noise rejection: runs of length 3 at (200,20) and (5,30), plus a length-4 run at x=300..303, y=80 → commit gives `x`=300, `y`=80.
- Line boundary: mask=1 for the last 2 pixels of row 10 and the first 2 pixels of row 11 → no hit, so `acc_hit`=0 and the commit holds `x`/`y` with `obj_valid`=0.
- Empty frame after a valid object → `x`/`y` hold at their old values, `obj_valid` drops to 0 and `pres_cnt` clears.
- Window limits: mask runs at `countx` ≥ `H_ACTIVE`, at `county` ≥ `V_ACTIVE`, or in a cycle where `frame_start`=1 and `de`=1 → all ignored. A run ending at `countx`=799 on row 599 is accepted (`x`=796 for `MIN_RUN`=4).
